// File: rtl/ibex_register_file_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port scoreboarded register file.
package ibex_rf_pkg;

  localparam int unsigned RF_ADDR_W_E = 4;
  localparam int unsigned RF_ADDR_W_I = 5;

  function automatic int unsigned rf_num_words(input bit rv32e);
    return rv32e ? (32'd1 << RF_ADDR_W_E) : (32'd1 << RF_ADDR_W_I);
  endfunction

endpackage

// File: rtl/ibex_register_file_mp_sb_wr_select.sv
// Picks the highest-index enabled write port whose address matches addr_i.
module ibex_rf_wr_select
  import ibex_rf_pkg::*;
#(
  parameter int unsigned NumWritePorts = 2,
  parameter int unsigned DataWidth     = 32
) (
  input  logic [RF_ADDR_W_I-1:0]               addr_i,
  input  logic [NumWritePorts*RF_ADDR_W_I-1:0] waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0]   wdata_i,
  input  logic [NumWritePorts-1:0]             we_i,
  output logic [NumWritePorts-1:0]             strobe_o,
  output logic [DataWidth-1:0]                 data_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    strobe_o = '0;
    data_o   = '0;
    for (int unsigned i = 0; i < NumWritePorts; i++) begin
      if (we_i[i] && (waddr_i[i*RF_ADDR_W_I +: RF_ADDR_W_I] == addr_i)) begin
        strobe_o    = '0;
        strobe_o[i] = 1'b1;
        data_o      = wdata_i[i*DataWidth +: DataWidth];
      end
    end
  end

endmodule

// File: rtl/ibex_register_file_mp_sb.sv
// Flop-based multi-port integer register file with per-register pending bits,
// optional write-through bypass and a registered protocol-error pulse.
module ibex_register_file_mp_sb
  import ibex_rf_pkg::*;
#(
  parameter bit                   RV32E         = 1'b0,
  parameter int unsigned          DataWidth     = 32,
  parameter int unsigned          NumReadPorts  = 2,
  parameter int unsigned          NumWritePorts = 2,
  parameter bit                   WriteThrough  = 1'b1,
  parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReadPorts*5-1:0]          raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]  rdata_o,
  output logic [NumReadPorts-1:0]            rvalid_o,
  input  logic [NumWritePorts*5-1:0]         waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]           we_i,
  input  logic                               issue_i,
  input  logic [4:0]                         issue_addr_i,
  output logic                               err_o
);

  localparam int unsigned NumWords = rf_num_words(RV32E);
  localparam int unsigned AW       = RF_ADDR_W_I;

  typedef struct packed {
    logic [DataWidth-1:0] val;
    logic                 pending;
  } rf_entry_t;

  localparam rf_entry_t ResetEntry = '{val: WordZeroVal, pending: 1'b0};

  rf_entry_t rf_words [32];
  logic      err_d, err_q;

  function automatic logic addr_valid(input logic [AW-1:0] a);
    return (a != '0) && !(RV32E && a[AW-1]);
  endfunction

  // x0 and addresses beyond the implemented words read as constant, never-pending entries.
  assign rf_words[0] = ResetEntry;
  for (genvar r = NumWords; r < 32; r++) begin : g_unimpl
    assign rf_words[r] = ResetEntry;
  end

  for (genvar r = 1; r < NumWords; r++) begin : g_reg
    logic [NumWritePorts-1:0] strobe;
    logic [DataWidth-1:0]     wdata;
    logic                     issue_hit;
    rf_entry_t                entry_d, entry_q;

    ibex_rf_wr_select #(
      .NumWritePorts(NumWritePorts),
      .DataWidth    (DataWidth)
    ) u_wr_select (
      .addr_i  (AW'(r)),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .we_i    (we_i),
      .strobe_o(strobe),
      .data_o  (wdata)
    );

    assign issue_hit = issue_i && (issue_addr_i == AW'(r));

    always_comb begin
      entry_d = entry_q;
      if (|strobe) begin
        entry_d.val     = wdata;
        entry_d.pending = 1'b0;
      end
      if (issue_hit) entry_d.pending = 1'b1;
    end

    always_ff @(posedge clk_i) begin
      // NOTE: state uses non-blocking assignment; the data words are reset too,
      // since this is a flop array rather than a RAM and post-reset reads must be defined.
      if (rst_i) entry_q <= ResetEntry;
      else       entry_q <= entry_d;
    end

    assign rf_words[r] = entry_q;
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AW-1:0]            ra;
    logic [NumWritePorts-1:0] byp_strobe;
    logic [DataWidth-1:0]     byp_data;
    logic [DataWidth-1:0]     rd_data;
    logic                     rd_valid;

    assign ra = raddr_i[p*AW +: AW];

    ibex_rf_wr_select #(
      .NumWritePorts(NumWritePorts),
      .DataWidth    (DataWidth)
    ) u_byp_select (
      .addr_i  (ra),
      .waddr_i (waddr_i),
      .wdata_i (wdata_i),
      .we_i    (we_i),
      .strobe_o(byp_strobe),
      .data_o  (byp_data)
    );

    always_comb begin
      if (!addr_valid(ra)) begin
        rd_data  = WordZeroVal;
        rd_valid = 1'b1;
      end else if (WriteThrough && (|byp_strobe)) begin
        rd_data  = byp_data;
        rd_valid = 1'b1;
      end else begin
        rd_data  = rf_words[ra].val;
        rd_valid = !rf_words[ra].pending;
      end
    end

    assign rdata_o[p*DataWidth +: DataWidth] = rd_data;
    assign rvalid_o[p]                       = rd_valid;
  end

  // Collision, out-of-range write, double issue and write to a non-pending register.
  always_comb begin
    err_d = 1'b0;
    for (int unsigned i = 0; i < NumWritePorts; i++) begin
      if (we_i[i]) begin
        if (RV32E && waddr_i[i*AW + AW - 1]) begin
          err_d = 1'b1;
        end else if ((waddr_i[i*AW +: AW] != '0) &&
                     !rf_words[waddr_i[i*AW +: AW]].pending &&
                     !(issue_i && (issue_addr_i == waddr_i[i*AW +: AW]))) begin
          err_d = 1'b1;
        end
        for (int unsigned j = i + 1; j < NumWritePorts; j++) begin
          if (we_i[j] && (waddr_i[j*AW +: AW] == waddr_i[i*AW +: AW]) &&
              (waddr_i[i*AW +: AW] != '0)) begin
            err_d = 1'b1;
          end
        end
      end
    end
    if (issue_i && addr_valid(issue_addr_i) && rf_words[issue_addr_i].pending) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_ibex_register_file_mp_sb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a register-array model.
module tb_ibex_register_file_mp_sb;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NR*5-1:0] raddr;
  logic [NR*DW-1:0] rdata, rdata_e;
  logic [NR-1:0]   rvalid, rvalid_e;
  logic [NW*5-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NW-1:0]   we;
  logic            issue;
  logic [4:0]      issue_addr;
  logic            err, err_e;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_val  [32];
  bit            m_pend [32];
  bit            m_err;

  always #5 clk = ~clk;

  ibex_register_file_mp_sb #(
    .RV32E(1'b0), .DataWidth(DW), .NumReadPorts(NR), .NumWritePorts(NW),
    .WriteThrough(1'b1), .WordZeroVal('0)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .issue_i(issue),
    .issue_addr_i(issue_addr), .err_o(err)
  );

  ibex_register_file_mp_sb #(
    .RV32E(1'b1), .DataWidth(DW), .NumReadPorts(NR), .NumWritePorts(NW),
    .WriteThrough(1'b1), .WordZeroVal('0)
  ) dut_e (
    .clk_i(clk), .rst_i(rst_i), .raddr_i(raddr), .rdata_o(rdata_e), .rvalid_o(rvalid_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .issue_i(issue),
    .issue_addr_i(issue_addr), .err_o(err_e)
  );

  // Model of the RV32I instance: array of words, pending flags, expected error.
  task automatic model_clock();
    logic [DW-1:0] nv [32];
    bit            np [32];
    bit            e;
    logic [4:0]    a, b;
    if (rst_i) begin
      for (int r = 0; r < 32; r++) begin m_val[r] = '0; m_pend[r] = 0; end
      m_err = 0;
      return;
    end
    e = 0;
    for (int i = 0; i < NW; i++) begin
      a = waddr[i*5 +: 5];
      if (!we[i]) continue;
      if (a != 0 && !m_pend[a] && !(issue && issue_addr == a)) e = 1;
      for (int j = i + 1; j < NW; j++) begin
        b = waddr[j*5 +: 5];
        if (we[j] && a == b && a != 0) e = 1;
      end
    end
    if (issue && issue_addr != 0 && m_pend[issue_addr]) e = 1;
    nv = m_val;
    np = m_pend;
    for (int i = 0; i < NW; i++) begin
      a = waddr[i*5 +: 5];
      if (we[i] && a != 0) begin nv[a] = wdata[i*DW +: DW]; np[a] = 0; end
    end
    if (issue && issue_addr != 0) np[issue_addr] = 1;
    m_val  = nv;
    m_pend = np;
    m_err  = e;
  endtask

  function automatic logic [DW-1:0] exp_rdata(int p);
    logic [4:0] a;
    a = raddr[p*5 +: 5];
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--)
      if (we[j] && waddr[j*5 +: 5] == a) return wdata[j*DW +: DW];
    return m_val[a];
  endfunction

  function automatic logic exp_rvalid(int p);
    logic [4:0] a;
    a = raddr[p*5 +: 5];
    if (a == 0) return 1'b1;
    for (int j = 0; j < NW; j++)
      if (we[j] && waddr[j*5 +: 5] == a) return 1'b1;
    return !m_pend[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    we    = '0;
    issue = 1'b0;
    wdata = '0;
  endtask

  task automatic set_wr(int port, logic [4:0] a, logic [DW-1:0] d);
    we[port]             = 1'b1;
    waddr[port*5 +: 5]   = a;
    wdata[port*DW +: DW] = d;
  endtask

  task automatic test_reset();
    idle();
    set_wr(0, 5'd5, 32'hDEAD);
    tick();
    idle();
    raddr[4:0] = 5'd5;
    raddr[9:5] = 5'd5;
    #1;
    checks++;
    if (rdata[DW-1:0] !== 32'hDEAD) begin
      failures++; $display("FAIL t1_pre_reset_x5 got=%h exp=%h", rdata[DW-1:0], 32'hDEAD);
    end
    rst_i = 1'b1;
    set_wr(0, 5'd5, 32'hBEEF);
    tick();
    tick();
    rst_i = 1'b0;
    idle();
    #1;
    checks++;
    if (rdata !== '0) begin failures++; $display("FAIL t1_reset_rdata got=%h exp=0", rdata); end
    checks++;
    if (rvalid !== 2'b11) begin failures++; $display("FAIL t1_reset_rvalid got=%b exp=11", rvalid); end
    checks++;
    if (err !== 1'b0 || err_e !== 1'b0) begin
      failures++; $display("FAIL t1_reset_err got=%b/%b exp=0/0", err, err_e);
    end
  endtask

  task automatic test_issue_wb();
    idle();
    issue = 1'b1; issue_addr = 5'd7;
    tick();
    idle();
    raddr[4:0] = 5'd7;
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL t2_issue_err got=%b exp=0", err); end
    checks++;
    if (rvalid[0] !== 1'b0) begin failures++; $display("FAIL t2_pending_rvalid got=%b exp=0", rvalid[0]); end
    set_wr(0, 5'd7, 32'h1234);
    #1;
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'h1234) begin
      failures++; $display("FAIL t2_bypass got=%b/%h exp=1/00001234", rvalid[0], rdata[DW-1:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL t2_wb_err got=%b exp=0", err); end
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'h1234) begin
      failures++; $display("FAIL t2_stored got=%b/%h exp=1/00001234", rvalid[0], rdata[DW-1:0]);
    end
  endtask

  task automatic test_collision();
    idle();
    issue = 1'b1; issue_addr = 5'd3;
    tick();
    idle();
    set_wr(0, 5'd3, 32'hA);
    set_wr(1, 5'd3, 32'hB);
    raddr[4:0] = 5'd3;
    #1;
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'hB) begin
      failures++; $display("FAIL t3_bypass got=%b/%h exp=1/0000000b", rvalid[0], rdata[DW-1:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL t3_collision_err got=%b exp=1", err); end
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'hB) begin
      failures++; $display("FAIL t3_stored got=%b/%h exp=1/0000000b", rvalid[0], rdata[DW-1:0]);
    end
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL t3_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_issue_write_same();
    idle();
    issue = 1'b1; issue_addr = 5'd9;
    set_wr(0, 5'd9, 32'h55);
    raddr[4:0] = 5'd9;
    #1;
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'h55) begin
      failures++; $display("FAIL t4_bypass got=%b/%h exp=1/00000055", rvalid[0], rdata[DW-1:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL t4_first_err got=%b exp=0", err); end
    checks++;
    if (rvalid[0] !== 1'b0 || rdata[DW-1:0] !== 32'h55) begin
      failures++; $display("FAIL t4_pending got=%b/%h exp=0/00000055", rvalid[0], rdata[DW-1:0]);
    end
    issue = 1'b1; issue_addr = 5'd9;
    set_wr(0, 5'd9, 32'h66);
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL t4_reissue_err got=%b exp=1", err); end
    checks++;
    if (rvalid[0] !== 1'b0 || rdata[DW-1:0] !== 32'h66) begin
      failures++; $display("FAIL t4_reissue got=%b/%h exp=0/00000066", rvalid[0], rdata[DW-1:0]);
    end
    set_wr(0, 5'd9, 32'h77);
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b0 || rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'h77) begin
      failures++;
      $display("FAIL t4_clear got=%b/%b/%h exp=0/1/00000077", err, rvalid[0], rdata[DW-1:0]);
    end
  endtask

  task automatic test_x0_rv32e();
    idle();
    set_wr(0, 5'd0, 32'hFFFF);
    raddr[4:0] = 5'd0;
    #1;
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== '0) begin
      failures++; $display("FAIL t5_x0_bypass got=%b/%h exp=1/0", rvalid[0], rdata[DW-1:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err !== 1'b0 || err_e !== 1'b0 || rdata[DW-1:0] !== '0) begin
      failures++; $display("FAIL t5_x0_write got=%b/%b/%h exp=0/0/0", err, err_e, rdata[DW-1:0]);
    end
    set_wr(0, 5'd20, 32'h1234_5678);
    raddr[4:0] = 5'd20;
    #1;
    checks++;
    if (rvalid_e[0] !== 1'b1 || rdata_e[DW-1:0] !== '0) begin
      failures++; $display("FAIL t5_e_oor_bypass got=%b/%h exp=1/0", rvalid_e[0], rdata_e[DW-1:0]);
    end
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[DW-1:0] !== 32'h1234_5678) begin
      failures++; $display("FAIL t5_i_x20_bypass got=%b/%h exp=1/12345678", rvalid[0], rdata[DW-1:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (err_e !== 1'b1) begin failures++; $display("FAIL t5_e_oor_err got=%b exp=1", err_e); end
    checks++;
    if (rdata_e[DW-1:0] !== '0 || rvalid_e[0] !== 1'b1) begin
      failures++; $display("FAIL t5_e_x20_read got=%b/%h exp=1/0", rvalid_e[0], rdata_e[DW-1:0]);
    end
    checks++;
    if (rdata[DW-1:0] !== 32'h1234_5678) begin
      failures++; $display("FAIL t5_i_x20_stored got=%h exp=12345678", rdata[DW-1:0]);
    end
  endtask

  task automatic test_double_issue();
    idle();
    issue = 1'b1; issue_addr = 5'd4;
    tick();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL t6_first_issue_err got=%b exp=0", err); end
    tick();
    idle();
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL t6_double_issue_err got=%b exp=1", err); end
    set_wr(1, 5'd4, 32'h44);
    tick();
    idle();
    raddr[9:5] = 5'd4;
    #1;
    checks++;
    if (err !== 1'b0 || rvalid[1] !== 1'b1 || rdata[2*DW-1:DW] !== 32'h44) begin
      failures++;
      $display("FAIL t6_clear got=%b/%b/%h exp=0/1/00000044", err, rvalid[1], rdata[2*DW-1:DW]);
    end
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_i      = ($urandom_range(0, 63) == 0);
      issue      = ($urandom_range(0, 2) == 0);
      issue_addr = rnd_addr();
      for (int i = 0; i < NW; i++) begin
        we[i]             = ($urandom_range(0, 1) == 0);
        waddr[i*5 +: 5]   = rnd_addr();
        wdata[i*DW +: DW] = $urandom;
      end
      for (int p = 0; p < NR; p++) raddr[p*5 +: 5] = rnd_addr();
      #1;
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rdata[p*DW +: DW] !== exp_rdata(p) || rvalid[p] !== exp_rvalid(p)) begin
          failures++;
          $display("FAIL rnd_read cyc=%0d port=%0d addr=%0d got=%b/%h exp=%b/%h", c, p,
                   raddr[p*5 +: 5], rvalid[p], rdata[p*DW +: DW], exp_rvalid(p), exp_rdata(p));
        end
      end
      tick();
      checks++;
      if (err !== m_err) begin
        failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, m_err);
      end
    end
    rst_i = 1'b0;
    idle();
  endtask

  initial begin
    rst_i      = 1'b1;
    raddr      = '0;
    waddr      = '0;
    issue_addr = '0;
    idle();
    tick();
    tick();
    rst_i = 1'b0;
    test_reset();
    test_issue_wb();
    test_collision();
    test_issue_write_same();
    test_x0_rv32e();
    test_double_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
